// File: rtl/fanin_pkg.sv
// Shared types and defaults for the fan-in join block.
// Optional data check: FANIN_DATA_CHECK_EN.
package fanin_pkg;

    localparam int DEFAULT_NUM_IN = 4;
    localparam int DEFAULT_DATA_W = 17;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    typedef logic [DEFAULT_DATA_W-1:0] token_t;

endpackage

// File: rtl/fanin_join_if.sv
// Handshake bundle: NUM_IN input streams plus one output stream.
// master = producer/consumer side, slave = the join.
interface fanin_join_if
    import fanin_pkg::*;
#(
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic [NUM_IN-1:0]             in_valid;
    logic [NUM_IN-1:0][DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]             in_ready;
    logic                          out_valid;
    logic [DATA_W-1:0]             out_data;
    logic                          out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fanin_skid_fifo.sv
// Two-entry registered output buffer; head entry drives data_out.
// Push while full is never issued by the join.
module fanin_skid_fifo
    import fanin_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] data_out
);
    localparam logic [1:0] S_EMPTY = BUF_EMPTY;
    localparam logic [1:0] S_ONE   = BUF_ONE;
    localparam logic [1:0] S_FULL  = BUF_FULL;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    // Occupancy transitions; head always holds the oldest token.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_d  = data_in;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_d = data_in;
                end else if (push) begin
                    tail_d  = data_in;
                    state_d = S_FULL;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // State and storage registers; reset discards buffered tokens.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign full     = (state_q == S_FULL);
    assign valid    = (state_q != S_EMPTY);
    assign data_out = head_q;

endmodule

// File: rtl/fanin_join.sv
// Fan-in join: fires when all participating inputs are valid.
// Optional control-bit mismatch flag: FANIN_DATA_CHECK_EN.
module fanin_join
    import fanin_pkg::*;
#(
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN-1:0]         cfg_en,
    input  logic [NUM_IN-1:0]         cfg_sel,
    input  logic [$clog2(NUM_IN)-1:0] cfg_primary,
    fanin_join_if.slave               bus,
    output logic                      err_mismatch
);
    logic [NUM_IN-1:0] part;
    logic              any_part;
    logic              all_valid;
    logic              full;
    logic              join_w;

    assign part      = cfg_en & cfg_sel;
    assign any_part  = |part;
    assign all_valid = &(~part | bus.in_valid);

    // Depends only on registered occupancy, never on out_ready.
    assign join_w = ~rst & any_part & all_valid & ~full;

    assign bus.in_ready = part & {NUM_IN{join_w}};

    fanin_skid_fifo #(.DATA_W(DATA_W)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (join_w),
        .data_in  (bus.in_data[cfg_primary]),
        .full     (full),
        .pop      (bus.out_valid & bus.out_ready),
        .valid    (bus.out_valid),
        .data_out (bus.out_data)
    );

`ifdef FANIN_DATA_CHECK_EN
    logic [NUM_IN-1:0] ctrl;
    logic              ctrl_p;
    logic              err_q, err_d;

    // Gather each port's control bit.
    always_comb begin
        ctrl = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            ctrl[i] = bus.in_data[i][DATA_W-1];
        end
    end

    assign ctrl_p = bus.in_data[cfg_primary][DATA_W-1];
    assign err_d  = err_q |
        (join_w & |(part & (ctrl ^ {NUM_IN{ctrl_p}})));

    // Sticky mismatch flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err_mismatch = err_q;
`else
    assign err_mismatch = 1'b0;
`endif

endmodule

// File: doc/fanin_join.md
# fanin_join

Synchronous fan-in join for the sparse-stream fabric: the receive-side counterpart of the fanout ready-combine. Gathers a configurable subset of NUM_IN valid/ready input streams, fires only when every participating source presents valid, and forwards one token (data taken from a configured primary port) into a 2-entry output buffer. Sits in front of any primitive that must consume several co-iterated streams in lock-step (intersect/union front-end, ALU operand gather).

## Interface
Parameters:
- NUM_IN, 4, number of input streams (2..22)
- DATA_W, 17, token width (16-bit payload + 1 control/stop bit)

Ports:
- clk  input  1  clock; single clock domain
- rst  input  1  reset, synchronous, active-high
- cfg_en  input  NUM_IN  per-port enable
- cfg_sel  input  NUM_IN  per-port participation bit; port i participates iff cfg_en[i] & cfg_sel[i]
- cfg_primary  input  $clog2(NUM_IN)  port whose data is forwarded
- in_valid  input  NUM_IN  per-port valid
- in_data  input  NUM_IN x DATA_W  per-port data
- in_ready  output  NUM_IN  per-port ready
- out_valid  output  1  output token valid
- out_data  output  DATA_W  output token
- out_ready  input  1  downstream ready
- err_mismatch  output  1  sticky data-mismatch flag (only with FANIN_DATA_CHECK_EN)

## Operation
- part = cfg_en & cfg_sel. all_valid = AND over i of (~part[i] | in_valid[i]); any_part = |part.
- join = any_part & all_valid & ~buf_full.
- in_ready[i] = part[i] & any_part & all_valid & ~buf_full; non-participating ports hold in_ready = 0.
- On join, every participating port transfers in the same cycle; in_data[cfg_primary] pushed into buffer.
- part == 0: no join ever; in_ready all 0; buffer drains normally.
- cfg_primary pointing at non-participating port: data still taken from that port's in_data (software error, not detected).
- Buffer states EMPTY, ONE, FULL (count 0/1/2):
  - EMPTY: push -> ONE.
  - ONE: push & ~pop -> FULL; pop & ~push -> EMPTY; push & pop -> ONE.
  - FULL: pop -> ONE; push impossible (in_ready low).
- pop = out_valid & out_ready. out_valid = (count != 0); out_data = head entry.
- Configuration quasi-static: changes only while rst high or buffer EMPTY with no join in flight; other changes unspecified.

## Timing
- Reset (rst high at clk edge): count = 0, out_valid = 0, out_data = 0, err_mismatch = 0; in_ready forced 0 while rst high.
- Reset mid-operation discards buffered tokens; no partial join survives.
- Latency: join at edge N -> out_valid high after edge N (visible cycle N+1).
- Throughput: 1 token/cycle sustained when out_ready held high.
- in_ready depends combinationally on in_valid of other participating ports and registered count only; no combinational path from out_ready to in_ready.
- out_valid/out_data registered; stable while out_valid & ~out_ready.

## Configuration
- FANIN_DATA_CHECK_EN defined: on each join, if any participating port's in_data[DATA_W-1] (control bit) differs from the primary's, err_mismatch sets next cycle and stays set until rst.
- Not defined: no comparison logic; err_mismatch tied 0.

## Structure
- Package fanin_pkg: DEFAULT_NUM_IN, DEFAULT_DATA_W, buffer state enum (BUF_EMPTY, BUF_ONE, BUF_FULL), token_t typedef.
- Sub-module fanin_skid_fifo: 2-entry registered FIFO (push, data_in, full, pop, valid, data_out, count state). Top holds join logic, ready generation and mismatch check.

## Test plan
- part = 4'b0011, in_valid = 4'b0001 -> no join, in_ready = 0; raise in_valid[1] -> in_ready = 4'b0011, out_valid next cycle with in_data[primary].
- part = 4'b1111, all valid continuously, out_ready = 1 -> 1 token/cycle, 8 tokens in 8 cycles plus 1 latency.
- out_ready = 0, 3 joins offered -> 2 accepted, buffer FULL, in_ready = 0; out_ready = 1 -> tokens in order, third accepted after one pop.
- cfg_en = 4'b1111, cfg_sel = 0 -> in_ready stays 0, out_valid stays 0 for 20 cycles.
- rst asserted with buffer FULL -> next cycle out_valid = 0, count 0, in_ready 0 during rst.
- With FANIN_DATA_CHECK_EN: primary control bit 1, other participant 0 at join -> err_mismatch = 1 next cycle, held until rst.
